tinyalu_cmd_driver: RTL

- Synthesisable, parametrised command engine that drives a TinyALU-style core (A/B/op/start/done/result).
- Accepts commands on a valid/ready stream and buffers them in a DEPTH-entry FIFO.
- Issues each command with the correct start/reset protocol, waits for done with a timeout, and returns exactly one response per command on a second valid/ready stream.
- Sits between the test/stimulus fabric and the ALU, replacing task-based driving with cycle-accurate hardware.

---
 rtl/tinyalu_pkg.sv | 43 ++++
 rtl/tinyalu_cmd_fifo.sv | 63 ++++++
 rtl/tinyalu_cmd_driver.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/tinyalu_pkg.sv
// tinyalu_pkg
//   Shared types for the TinyALU command driver: the ALU operation
//   encoding, the response status codes and the driver FSM states.
//   It also holds a small helper that tells which operations go through
//   the ALU's start/done handshake.
package tinyalu_pkg;

   typedef enum logic [2:0] {
      no_op  = 3'b000,
      add_op = 3'b001,
      and_op = 3'b010,
      xor_op = 3'b011,
      mul_op = 3'b100,
      rst_op = 3'b111
   } operation_t;

   typedef enum logic [1:0] {
      ST_OK      = 2'b00,
      ST_TIMEOUT = 2'b01,
      ST_ILLEGAL = 2'b10
   } status_t;

   typedef enum logic [2:0] {
      IDLE,
      EXEC,
      NOOP,
      RST,
      RESP
   } state_t;

   localparam int OP_W = 3;

   // True for operations that wait on alu_done.
   function automatic logic is_arith(input logic [OP_W-1:0] op);
      logic r;
      case (op)
         add_op, and_op, xor_op, mul_op: r = 1'b1;
         default:                        r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/tinyalu_cmd_fifo.sv
// tinyalu_cmd_fifo
//   Command buffer for the TinyALU driver. Each entry holds {op, a, b}.
//   Ports:
//     clk, reset      clock, asynchronous active-high reset (pointers only)
//     push, wdata     write one entry; ignored while full
//     pop, rdata      rdata is the head entry; pop drops it (ignored if empty)
//     full, empty     occupancy flags
module tinyalu_cmd_fifo
   import tinyalu_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [OP_W+2*DATA_W-1:0]   wdata,
   input  logic                       pop,
   output logic [OP_W+2*DATA_W-1:0]   rdata,
   output logic                       full,
   output logic                       empty
);

   localparam int W  = OP_W + 2*DATA_W;
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Storage carries no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/tinyalu_cmd_driver.sv
// tinyalu_cmd_driver
//   Hardware command engine for a TinyALU-style core. Commands arrive on a
//   valid/ready stream, are queued in a DEPTH-entry FIFO, are issued to the
//   ALU with the start / reset_n protocol, and each produces exactly one
//   response on a second valid/ready stream, in command order.
//   Ports:
//     clk, reset                      clock, asynchronous active-high reset
//     cmd_valid/cmd_ready             command stream; cmd_op/cmd_a/cmd_b payload
//     rsp_valid/rsp_ready             response stream; rsp_op/rsp_result/rsp_status
//     alu_a/alu_b/alu_op/alu_start    registered drive to the ALU
//     alu_reset_n                     registered active-low ALU reset
//     alu_done/alu_result             from the ALU
//     busy                            FSM not idle or commands still queued
module tinyalu_cmd_driver
   import tinyalu_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int DEPTH      = 4,
   parameter int TIMEOUT    = 16,
   parameter int RST_CYCLES = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [2:0]          cmd_op,
   input  logic [DATA_W-1:0]   cmd_a,
   input  logic [DATA_W-1:0]   cmd_b,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [2:0]          rsp_op,
   output logic [2*DATA_W-1:0] rsp_result,
   output logic [1:0]          rsp_status,
   output logic [DATA_W-1:0]   alu_a,
   output logic [DATA_W-1:0]   alu_b,
   output logic [2:0]          alu_op,
   output logic                alu_start,
   output logic                alu_reset_n,
   input  logic                alu_done,
   input  logic [2*DATA_W-1:0] alu_result,
   output logic                busy
);

   localparam int CNT_MAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   state_t                   state, state_d;
   logic [CNT_W-1:0]         cnt, cnt_d;
   logic                     fifo_pop, fifo_full, fifo_empty;
   logic [OP_W+2*DATA_W-1:0] fifo_rdata;
   logic [2:0]               head_op;
   logic [DATA_W-1:0]        head_a, head_b;
   logic                     alu_load;
   logic                     start_d, reset_n_d;
   logic                     rsp_load;
   logic [2:0]               rsp_op_d;
   logic [2*DATA_W-1:0]      rsp_result_d;
   status_t                  rsp_status_d, rsp_status_q;

   tinyalu_cmd_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (cmd_valid),
      .wdata ({cmd_op, cmd_a, cmd_b}),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign {head_op, head_a, head_b} = fifo_rdata;
   assign cmd_ready  = !fifo_full;
   assign rsp_valid  = (state == RESP);
   assign rsp_status = rsp_status_q;
   assign busy       = (state != IDLE) || !fifo_empty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
      end
   end

   always_comb begin
      state_d      = state;
      cnt_d        = cnt;
      fifo_pop     = 1'b0;
      alu_load     = 1'b0;
      rsp_load     = 1'b0;
      rsp_op_d     = alu_op;
      rsp_result_d = '0;
      rsp_status_d = ST_OK;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               if (is_arith(head_op)) begin
                  alu_load = 1'b1;
                  cnt_d    = '0;
                  state_d  = EXEC;
               end else if (head_op == no_op) begin
                  alu_load = 1'b1;
                  state_d  = NOOP;
               end else if (head_op == rst_op) begin
                  alu_load = 1'b1;
                  cnt_d    = CNT_W'(RST_CYCLES);
                  state_d  = RST;
               end else begin
                  // Unknown code: answer directly, ALU drive left as is.
                  rsp_load     = 1'b1;
                  rsp_op_d     = head_op;
                  rsp_status_d = ST_ILLEGAL;
                  state_d      = RESP;
               end
            end
         end
         EXEC: begin
            // Done is checked first so it wins over a coincident timeout.
            if (alu_done) begin
               rsp_load     = 1'b1;
               rsp_result_d = alu_result;
               state_d      = RESP;
            end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
               rsp_load     = 1'b1;
               rsp_status_d = ST_TIMEOUT;
               state_d      = RESP;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         NOOP: begin
            rsp_load = 1'b1;
            state_d  = RESP;
         end
         RST: begin
            if (cnt == CNT_W'(1)) begin
               rsp_load = 1'b1;
               state_d  = RESP;
            end else begin
               cnt_d = cnt - CNT_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Start and reset_n follow the state being entered, so they change
      // on the same edge as the state transition.
      start_d   = (state_d == EXEC) || (state_d == NOOP);
      reset_n_d = (state_d != RST);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_a        <= '0;
         alu_b        <= '0;
         alu_op       <= no_op;
         alu_start    <= 1'b0;
         alu_reset_n  <= 1'b0;
         rsp_op       <= no_op;
         rsp_result   <= '0;
         rsp_status_q <= ST_OK;
      end else begin
         alu_start   <= start_d;
         alu_reset_n <= reset_n_d;
         if (alu_load) begin
            alu_op <= head_op;
            alu_a  <= head_a;
            alu_b  <= head_b;
         end
         if (rsp_load) begin
            rsp_op       <= rsp_op_d;
            rsp_result   <= rsp_result_d;
            rsp_status_q <= rsp_status_d;
         end
      end
   end

endmodule
